interfaz_tx_fifo: RTL and testbench

Parametrised successor of the ALU-to-TX interface. Buffers ALU results in a DEPTH-entry FIFO so back-to-back results are not lost while the UART TX is busy. Splits results wider than one UART byte into NB_BYTE-wide words and pushes them to the TX one at a time, in a selectable byte order. Sits between the ALU result/done pair and the UART TX data/start pair.

---
 rtl/interfaz_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_interfaz_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interfaz_tx_fifo.sv
// interfaz_tx_fifo: buffers ALU results in a small FIFO and sends each one
// to the UART TX as NB_BYTE-wide words. Byte order is set by LSB_FIRST.
// A new word is started only while the TX holds a free credit (tx_free).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no result in flight; leave as soon as the FIFO is non-empty
// LOAD    | pop the FIFO head into the shift register, clear byte counter
// WAIT_TX | hold until the TX is free, then register the current byte
// PUSH    | o_int_tx high for one cycle; shift to the next byte
module interfaz_tx_fifo #(
    parameter int NB_DATA   = 16,
    parameter int NB_BYTE   = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NB_DATA-1:0]       i_resultado,
    input  logic                     i_done_alu,
    input  logic                     i_done_tx,
    input  logic                     i_clr_ovf,
    output logic [NB_BYTE-1:0]       o_data,
    output logic                     o_int_tx,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NBYTES = NB_DATA / NB_BYTE;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_TX = 2'd2,
        PUSH    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 tx_free_q, tx_free_d;
    logic [NB_DATA-1:0]   sh_q, sh_d;
    logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [NB_BYTE-1:0]   data_q, data_d;

    logic [NB_DATA-1:0]   mem [DEPTH];

    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push;
    logic                 wr_en;
    logic                 drop;
    logic                 last_byte;
    logic                 start_push;
    logic [NB_BYTE-1:0]   cur_byte;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign pop        = (state_q == LOAD);
    assign push       = (state_q == PUSH);
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign wr_en      = i_done_alu && (!full || pop);
    assign drop       = i_done_alu && !wr_en;
    assign last_byte  = (byte_cnt_q == CW'(NBYTES - 1));
    assign start_push = (state_q == WAIT_TX) && (tx_free_q || i_done_tx);
    assign cur_byte   = (LSB_FIRST != 0) ? sh_q[NB_BYTE-1:0]
                                         : sh_q[NB_DATA-1 -: NB_BYTE];

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= i_resultado;
        end
    end

    // FIFO bookkeeping, overflow flag and TX credit.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        tx_free_d = tx_free_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        // Consuming the credit wins over a stray done strobe in the push cycle.
        if (push) begin
            tx_free_d = 1'b0;
        end else if (i_done_tx) begin
            tx_free_d = 1'b1;
        end
    end

    // State register and all other sequential state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_free_q  <= 1'b1;
            sh_q       <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_free_q  <= tx_free_d;
            sh_q       <= sh_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : LOAD;
            LOAD:    state_d = WAIT_TX;
            WAIT_TX: state_d = start_push ? PUSH : WAIT_TX;
            PUSH:    state_d = last_byte ? IDLE : WAIT_TX;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic: shift register, byte counter, output word.
    always_comb begin
        sh_d       = sh_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        o_int_tx   = 1'b0;
        case (state_q)
            LOAD: begin
                sh_d       = mem[rd_ptr_q];
                byte_cnt_d = '0;
            end
            WAIT_TX: begin
                if (start_push) begin
                    data_d = cur_byte;
                end
            end
            PUSH: begin
                o_int_tx   = 1'b1;
                sh_d       = (LSB_FIRST != 0) ? (sh_q >> NB_BYTE) : (sh_q << NB_BYTE);
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
            default: begin
                sh_d = sh_q;
            end
        endcase
    end

    assign o_data     = data_q;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_interfaz_tx_fifo.sv
// Directed bench for interfaz_tx_fifo: one instance with default parameters
// and one with MSB-first ordering.
module tb_interfaz_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] resultado;
    logic        done_alu;
    logic        done_tx;
    logic        clr_ovf;
    logic [7:0]  data;
    logic        int_tx;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        ovf;

    logic        done_alu_m;
    logic        done_tx_m;
    logic [7:0]  data_m;
    logic        int_tx_m;
    logic        full_m;
    logic        empty_m;
    logic [2:0]  count_m;
    logic        ovf_m;

    int errors = 0;
    int checks = 0;

    interfaz_tx_fifo #(.NB_DATA(16), .NB_BYTE(8), .DEPTH(4), .LSB_FIRST(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_resultado (resultado),
        .i_done_alu  (done_alu),
        .i_done_tx   (done_tx),
        .i_clr_ovf   (clr_ovf),
        .o_data      (data),
        .o_int_tx    (int_tx),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (ovf)
    );

    interfaz_tx_fifo #(.NB_DATA(16), .NB_BYTE(8), .DEPTH(4), .LSB_FIRST(0)) dut_m (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_resultado (resultado),
        .i_done_alu  (done_alu_m),
        .i_done_tx   (done_tx_m),
        .i_clr_ovf   (clr_ovf),
        .o_data      (data_m),
        .o_int_tx    (int_tx_m),
        .o_full      (full_m),
        .o_empty     (empty_m),
        .o_count     (count_m),
        .o_overflow  (ovf_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the selected instance pulses o_int_tx, bounded.
    task automatic wait_push(input bit sel, input string tag, output int n);
        n = 0;
        while (((sel ? int_tx_m : int_tx) !== 1'b1) && (n < 100)) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (sel ? int_tx_m : int_tx)}, 32'd1);
    endtask

    logic [7:0] exp_seq [10];
    int n;
    int pushes;

    initial begin
        rst_n      = 1'b0;
        resultado  = '0;
        done_alu   = 1'b0;
        done_tx    = 1'b0;
        clr_ovf    = 1'b0;
        done_alu_m = 1'b0;
        done_tx_m  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_ovf",   {31'd0, ovf},   32'd0);
        chk("rst_data",  {24'd0, data},  32'd0);
        chk("rst_int",   {31'd0, int_tx}, 32'd0);
        chk("rst_data_m", {24'd0, data_m}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: LSB first, latency, single-cycle pulses, TX echo after 10 cycles
        resultado = 16'hA55A;
        done_alu  = 1'b1;
        tick();
        done_alu  = 1'b0;
        chk("t1_count_after_write", {29'd0, count}, 32'd1);
        wait_push(0, "t1_push0_timeout", n);
        chk("t1_latency", n + 1, 32'd4);
        chk("t1_byte0", {24'd0, data}, 32'h5A);
        tick();
        chk("t1_pulse_width", {31'd0, int_tx}, 32'd0);
        chk("t1_data_held", {24'd0, data}, 32'h5A);
        for (int i = 0; i < 9; i++) tick();
        chk("t1_no_push_without_done", {31'd0, int_tx}, 32'd0);
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("t1_push1", {31'd0, int_tx}, 32'd1);
        chk("t1_byte1", {24'd0, data}, 32'hA5);
        tick();
        chk("t1_pulse1_width", {31'd0, int_tx}, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("t1_empty_end", {31'd0, empty}, 32'd1);
        chk("t1_count_end", {29'd0, count}, 32'd0);

        // 2: MSB first
        resultado  = 16'h1234;
        done_alu_m = 1'b1;
        tick();
        done_alu_m = 1'b0;
        wait_push(1, "t2_push0_timeout", n);
        chk("t2_byte0", {24'd0, data_m}, 32'h12);
        tick();
        done_tx_m = 1'b1;
        tick();
        done_tx_m = 1'b0;
        wait_push(1, "t2_push1_timeout", n);
        chk("t2_byte1", {24'd0, data_m}, 32'h34);
        tick();
        done_tx_m = 1'b1;
        tick();
        done_tx_m = 1'b0;
        chk("t2_empty_end", {31'd0, empty_m}, 32'd1);

        // 3: TX stalled, six back-to-back results into a 4-deep FIFO
        for (int i = 1; i <= 6; i++) begin
            resultado = 16'(i);
            done_alu  = 1'b1;
            tick();
            if (i == 4) begin
                chk("t3_first_push", {31'd0, int_tx}, 32'd1);
                chk("t3_first_byte", {24'd0, data}, 32'h01);
            end
        end
        done_alu = 1'b0;
        chk("t3_full",  {31'd0, full}, 32'd1);
        chk("t3_count", {29'd0, count}, 32'd4);
        chk("t3_ovf",   {31'd0, ovf}, 32'd1);

        // 6a: clear with no drop, together with the TX release
        clr_ovf = 1'b1;
        done_tx = 1'b1;
        tick();
        clr_ovf = 1'b0;
        done_tx = 1'b0;
        chk("t6_clr_ovf", {31'd0, ovf}, 32'd0);
        chk("t3_push_hi", {31'd0, int_tx}, 32'd1);
        chk("t3_byte_hi", {24'd0, data}, 32'h00);
        tick();
        chk("t4_full_idle", {31'd0, full}, 32'd1);
        tick();

        // 4: write while full in the LOAD cycle
        resultado = 16'h0007;
        done_alu  = 1'b1;
        tick();
        done_alu  = 1'b0;
        chk("t4_count", {29'd0, count}, 32'd4);
        chk("t4_full",  {31'd0, full}, 32'd1);
        chk("t4_ovf",   {31'd0, ovf}, 32'd0);

        // Drain: results 2..5 then 7, never the dropped 6
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h00;
        exp_seq[2] = 8'h03; exp_seq[3] = 8'h00;
        exp_seq[4] = 8'h04; exp_seq[5] = 8'h00;
        exp_seq[6] = 8'h05; exp_seq[7] = 8'h00;
        exp_seq[8] = 8'h07; exp_seq[9] = 8'h00;
        for (int k = 0; k < 10; k++) begin
            done_tx = 1'b1;
            tick();
            done_tx = 1'b0;
            wait_push(0, $sformatf("t3_drain_timeout_%0d", k), n);
            chk($sformatf("t3_drain_byte_%0d", k), {24'd0, data}, {24'd0, exp_seq[k]});
            tick();
        end
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        pushes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int_tx === 1'b1) pushes++;
        end
        chk("t3_no_extra_push", pushes, 32'd0);
        chk("t3_empty_end", {31'd0, empty}, 32'd1);

        // 6b: clear coincident with a drop keeps the flag set
        for (int i = 0; i < 6; i++) begin
            resultado = 16'h0011 + 16'(i);
            done_alu  = 1'b1;
            clr_ovf   = (i == 5);
            tick();
        end
        done_alu = 1'b0;
        clr_ovf  = 1'b0;
        chk("t6_drop_wins", {31'd0, ovf}, 32'd1);

        rst_n = 1'b0;
        tick();
        tick();
        chk("t5_pre_rst_count", {29'd0, count}, 32'd0);
        chk("t5_pre_rst_ovf",   {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 5: async reset between the two bytes of 16'hBEEF
        resultado = 16'hBEEF;
        done_alu  = 1'b1;
        tick();
        resultado = 16'h1111;
        tick();
        done_alu  = 1'b0;
        wait_push(0, "t5_push0_timeout", n);
        chk("t5_byte0", {24'd0, data}, 32'hEF);
        chk("t5_count_before", {29'd0, count}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_int",   {31'd0, int_tx}, 32'd0);
        chk("t5_async_data",  {24'd0, data}, 32'd0);
        chk("t5_async_count", {29'd0, count}, 32'd0);
        chk("t5_async_empty", {31'd0, empty}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        pushes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (int_tx === 1'b1) pushes++;
        end
        chk("t5_no_push_after_rst", pushes, 32'd0);
        chk("t5_data_after_rst", {24'd0, data}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
